// File: rtl/nr_reciprocal_seq_if.sv
// Purpose : operand/result handshake bundle for the sequential Newton-Raphson reciprocal engine.
// Latency : n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid    operand a is valid                (master -> slave)
//   in_ready    engine can accept an operand      (slave  -> master)
//   a           operand, sign-magnitude Q-format  (master -> slave)
//   out_valid   result is valid                   (slave  -> master)
//   out_ready   consumer accepts the result       (master -> slave)
//   result      1/a, sign-magnitude Q-format      (slave  -> master)
//   div_by_zero result qualifier, |a| was 0       (slave  -> master)
//   busy        engine is not idle                (slave  -> master)
interface nr_reciprocal_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         div_by_zero;
    logic         busy;

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, result, div_by_zero, busy
    );

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, result, div_by_zero, busy
    );
endinterface

// File: rtl/nr_reciprocal_seq.sv
// Purpose : sign-magnitude fixed-point reciprocal by ITERS Newton-Raphson steps on one shared multiplier.
// Latency : out_valid after 1+2*ITERS edges past acceptance (1 edge for a zero operand).
// Backpressure: result held in DONE until out_ready; no operand accepted until the result handshake.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset, aborts any operation in flight
//   bus    nr_reciprocal_seq_if.slave: in_valid/in_ready/a, out_valid/out_ready/result/div_by_zero, busy
//
// Datapath width assumes the constant 2.0 (2<<Q) fits in N-1 magnitude bits, i.e. Q <= N-3.
module nr_reciprocal_seq #(
    parameter int N     = 32,
    parameter int Q     = 16,
    parameter int ITERS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    nr_reciprocal_seq_if.slave  bus
);

    localparam int M  = N - 1;            // magnitude width
    localparam int PW = $clog2(M);        // width of a bit index into the magnitude

    localparam logic [M-1:0] TWO    = {{(M-2){1'b0}}, 2'b10} << Q;
    localparam logic [M-1:0] ONE_LSB = {{(M-1){1'b0}}, 1'b1};
    localparam logic [3:0]   ITERS_C = 4'(ITERS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MUL_AX,
        S_MUL_XE,
        S_DONE
    } state_t;

    state_t         state_q,  state_d;
    logic           sign_q,   sign_d;
    logic [M-1:0]   mag_q,    mag_d;
    logic [M-1:0]   x_q,      x_d;
    logic [M-1:0]   t_q,      t_d;
    logic [3:0]     iter_q,   iter_d;
    logic [N-1:0]   result_q, result_d;
    logic           dbz_q,    dbz_d;

    // ------------------------------------------------------------------
    // Leading-one detect and seed: x0 = 1 << min(2Q-1-p, N-2) puts m*x0
    // into [0.5, 1), which keeps every iteration inside convergence.
    // ------------------------------------------------------------------
    logic [PW-1:0]  msb_idx;
    logic [M-1:0]   x0;
    int             seed_sh;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < M; i++) begin
            if (mag_q[i]) begin
                msb_idx = PW'(i);
            end
        end
    end

    always_comb begin
        seed_sh = 2 * Q - 1 - int'(msb_idx);
        if (seed_sh > N - 2) begin
            seed_sh = N - 2;
        end
        if (seed_sh < 0) begin
            seed_sh = 0;
        end
        x0 = ONE_LSB << seed_sh;
    end

    // ------------------------------------------------------------------
    // Shared multiplier. MUL_AX forms t = m*x, MUL_XE forms x = x*e.
    // Product is rescaled by Q (truncating) and saturated to M bits.
    // ------------------------------------------------------------------
    logic [M-1:0]   mul_u;
    logic [M-1:0]   mul_v;
    logic [M-1:0]   err;
    logic [2*M-1:0] prod_full;
    logic [2*M-1:0] prod_shift;
    logic [M-1:0]   prod_sat;

    // e = 2 - t, floored at zero when t overshoots 2.0.
    always_comb begin
        err = '0;
        if (t_q <= TWO) begin
            err = TWO - t_q;
        end
    end

    always_comb begin
        mul_u = x_q;
        mul_v = err;
        if (state_q == S_MUL_AX) begin
            mul_u = mag_q;
            mul_v = x_q;
        end
    end

    always_comb begin
        prod_full  = {{M{1'b0}}, mul_u} * {{M{1'b0}}, mul_v};
        prod_shift = prod_full >> Q;
        prod_sat   = prod_shift[M-1:0];
        if (|prod_shift[2*M-1:M]) begin
            prod_sat = '1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    logic [3:0] iter_inc;

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        x_d      = x_q;
        t_d      = t_q;
        iter_d   = iter_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        iter_inc = iter_q + 4'd1;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.a[N-1];
                    mag_d   = bus.a[N-2:0];
                    state_d = S_INIT;
                end
            end

            S_INIT: begin
                if (mag_q == '0) begin
                    // Largest representable magnitude, sign preserved (-0 gives a negative result).
                    result_d = {sign_q, {M{1'b1}}};
                    dbz_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    x_d     = x0;
                    iter_d  = '0;
                    state_d = S_MUL_AX;
                end
            end

            S_MUL_AX: begin
                t_d     = prod_sat;
                state_d = S_MUL_XE;
            end

            S_MUL_XE: begin
                x_d    = prod_sat;
                iter_d = iter_inc;
                if (iter_inc == ITERS_C) begin
                    result_d = {sign_q, prod_sat};
                    dbz_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_MUL_AX;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            x_q      <= '0;
            t_q      <= '0;
            iter_q   <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            x_q      <= x_d;
            t_q      <= t_d;
            iter_q   <= iter_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    // Outputs are pure decodes of registered state, so nothing partial can leak out.
    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_nr_reciprocal_seq.sv
// Purpose : directed and model-checked stimulus for nr_reciprocal_seq.
// Latency : n/a.
// Backpressure: drives out_ready low for a stretch to hold a result in DONE.
module tb_nr_reciprocal_seq;

    localparam int N     = 32;
    localparam int Q     = 16;
    localparam int ITERS = 5;
    localparam int LAT   = 1 + 2 * ITERS;

    logic clk;
    logic rst_n;

    nr_reciprocal_seq_if #(.N(N)) bus ();

    nr_reciprocal_seq #(.N(N), .Q(Q), .ITERS(ITERS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        end
    endtask

    // Bit-accurate reference: Q-rescaled truncating multiply with saturation.
    function automatic logic [30:0] mulq(input logic [30:0] u, input logic [30:0] v);
        logic [61:0] p;
        p = {31'b0, u} * {31'b0, v};
        p = p >> Q;
        if (p >= 62'h8000_0000) begin
            return '1;
        end
        return p[30:0];
    endfunction

    function automatic logic [32:0] model(input logic [31:0] av);
        logic [30:0] m, x, t, e;
        int          p, sh;
        m = av[30:0];
        if (m == 0) begin
            return {1'b1, av[31], 31'h7FFF_FFFF};
        end
        p = 0;
        for (int i = 0; i < 31; i++) begin
            if (m[i]) p = i;
        end
        sh = 2 * Q - 1 - p;
        if (sh > N - 2) sh = N - 2;
        x = 31'd1 << sh;
        for (int k = 0; k < ITERS; k++) begin
            t = mulq(m, x);
            e = (t > 31'h20000) ? 31'd0 : 31'h20000 - t;
            x = mulq(x, e);
        end
        return {1'b0, av[31], x};
    endfunction

    // One complete operation with out_ready already high.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] exp_res,
                          input logic exp_dbz, input int exp_lat);
        int n;
        wait_in_ready();
        bus.in_valid = 1'b1;
        bus.a        = av;
        step();
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEAD_BEEF;  // must be ignored while busy
        wait_out(n);
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_res"}, 64'(bus.result), 64'(exp_res));
        chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        step();
        chk({tag, "_ovld_clr"}, 64'(bus.out_valid), 64'd0);
    endtask

    logic [30:0] x_trace [6];
    logic [31:0] rand_a  [8];

    initial begin
        int n;
        int acc_cyc, hs_cyc;
        logic [32:0] mr;

        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        x_trace[0] = 31'h4000; x_trace[1] = 31'h6000; x_trace[2] = 31'h7800;
        x_trace[3] = 31'h7F80; x_trace[4] = 31'h7FFF; x_trace[5] = 31'h7FFF;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();

        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        rst_n = 1'b1;
        step();

        // 2.0 with the iterate traced after each update.
        bus.in_valid = 1'b1;
        bus.a        = 32'h0002_0000;
        step();
        bus.in_valid = 1'b0;
        chk("two_busy", 64'(bus.busy), 64'd1);
        for (int e = 1; e <= LAT; e++) begin
            step();
            if (e % 2 == 1) begin
                chk($sformatf("two_x%0d", (e - 1) / 2), 64'(dut.x_q), 64'(x_trace[(e - 1) / 2]));
            end
            if (e == LAT - 1) chk("two_ovld_early", 64'(bus.out_valid), 64'd0);
            if (e == LAT)     chk("two_ovld", 64'(bus.out_valid), 64'd1);
        end
        chk("two_res", 64'(bus.result), 64'h0000_7FFF);
        chk("two_dbz", 64'(bus.div_by_zero), 64'd0);
        step();
        chk("two_in_ready", 64'(bus.in_ready), 64'd1);

        run_op("one",  32'h0001_0000, 32'h0000_FFFF, 1'b0, LAT);
        run_op("mone", 32'h8001_0000, 32'h8000_FFFF, 1'b0, LAT);
        run_op("zero", 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1);
        run_op("nzero", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);

        // Backpressure: result held, a pending operand waits for the handshake.
        bus.out_ready = 1'b0;
        wait_in_ready();
        bus.in_valid  = 1'b1;
        bus.a         = 32'h0002_0000;
        step();
        bus.a         = 32'h0001_0000;
        wait_out(n);
        chk("bp_lat", 64'(n), 64'(LAT));
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_hold_ovld", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_inrdy", 64'(bus.in_ready), 64'd0);
            chk("bp_hold_res", 64'(bus.result), 64'h0000_7FFF);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_hs_inrdy", 64'(bus.in_ready), 64'd1);
        chk("bp_hs_ovld", 64'(bus.out_valid), 64'd0);
        step();
        bus.in_valid = 1'b0;
        chk("bp_next_acc", 64'(bus.busy), 64'd1);
        wait_out(n);
        chk("bp_next_lat", 64'(n), 64'(LAT));
        chk("bp_next_res", 64'(bus.result), 64'h0000_FFFF);
        step();

        // Reset during MUL_XE of the second iteration.
        bus.in_valid = 1'b1;
        bus.a        = 32'h0002_0000;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_result", 64'(bus.result), 64'd0);
        chk("arst_dbz", 64'(bus.div_by_zero), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op("post_rst", 32'h0002_0000, 32'h0000_7FFF, 1'b0, LAT);

        // Back-to-back random operands, in_valid held high throughout.
        for (int i = 0; i < 8; i++) begin
            rand_a[i] = {1'($urandom_range(0, 1)), 31'($urandom_range(1, 32'h7FFF_FFFF))};
        end
        wait_in_ready();
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = rand_a[i];
            if (i > 0) begin
                chk($sformatf("b2b%0d_rdy_after_hs", i), 64'(bus.in_ready), 64'd1);
            end
            step();
            acc_cyc = cyc;
            if (i == 7) bus.in_valid = 1'b0;
            if (i < 7)  bus.a = rand_a[i + 1];
            wait_out(n);
            mr = model(rand_a[i]);
            chk($sformatf("b2b%0d_res_a%08h", i, rand_a[i]), 64'(bus.result), 64'(mr[31:0]));
            chk($sformatf("b2b%0d_dbz", i), 64'(bus.div_by_zero), 64'(mr[32]));
            step();
            hs_cyc = cyc;
            chk($sformatf("b2b%0d_op_cycles", i), 64'(hs_cyc - acc_cyc), 64'(2 + 2 * ITERS));
        end
        step();
        chk("b2b_idle", 64'(bus.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
